figure_move_gen_seq: RTL
========================

// Module: figure_move_gen_seq
// PURPOSE
//  Sequential, parametrised move generator for one selected chess figure. On start it snapshots the
//  board, walks candidate squares one per cycle (rays for sliders, offset lists for leapers/pawns)
//  and returns a target mask plus a move count. Sits between the cursor/selection logic and the
//  move-commit logic; one request is in flight at a time.
// PARAMETERS
//  N       8  board dimension (squares per row/col); power of two, 4..16
//  CODE_W  4  figure code width; 0 = empty, 1..6 white P,R,N,B,Q,K; 7..12 black P,R,N,B,Q,K
//  CW      $clog2(N)  derived: row/col index width (localparam)
// PORTS
//  clk            in   1          system clock, rising edge
//  rst            in   1          asynchronous, active-low reset
//  start          in   1          request pulse; accepted only when busy=0
//  selected_figure in  CODE_W     figure code, sampled on accepted start
//  position       in   2*CW       [CW-1:0]=col, [2CW-1:CW]=row; row 0 = top (black home side)
//  board          in   N*N*CODE_W flattened board; square s=row*N+col at [s*CODE_W +: CODE_W]
//  busy           out  1          high from cycle after accepted start until done
//  done           out  1          1-cycle pulse: moves/move_cnt/err valid
//  moves          out  N*N        target mask, bit s=row*N+col; held until next accepted start
//  move_cnt       out  2*CW+1     number of set bits in moves
//  err            out  1          selected code empty/>12 or square code mismatch; held like moves
// BEHAVIOUR
//  - Reset (rst=0, async): busy=0, done=0, moves=0, move_cnt=0, err=0, FSM->IDLE. Mid-op reset aborts.
//  - FSM: IDLE -> SETUP -> SCAN -> FIN -> IDLE.
//    IDLE: start&!busy -> capture board, figure, position; clear moves/move_cnt/err; -> SETUP.
//    SETUP (1 cyc): decode colour/type; invalid code or board[position]!=figure -> err=1, -> FIN.
//    SCAN: exactly one candidate square examined per cycle (see below).
//    FIN (1 cyc): done=1, busy=0 on the following cycle; -> IDLE.
//  - start while busy: ignored, no effect. start in same cycle as FIN: ignored (busy still 1).
//  - Board/position changes after capture have no effect on the running request.
//  - Square classification vs. mover colour: empty / enemy / own. Off-board = step leaves 0..N-1.
//  - Sliders (R: 4 orth, B: 4 diag, Q: 8), direction order N,E,S,W,NE,SE,SW,NW (skip unused):
//    each SCAN cycle examines cur+dir. off-board: no mark, next dir. empty: mark, continue.
//    enemy: mark, next dir. own: no mark, next dir. Every ray termination consumes its cycle.
//  - Leapers (N, K): 8 fixed offsets, one per cycle (8 SCAN cycles always); mark if on-board & !own.
//  - Pawn: 4 checks, one per cycle (4 SCAN cycles): fwd1 empty; fwd2 if on start row and fwd1,fwd2
//    empty; diag-left enemy; diag-right enemy. White fwd = row-1, start row N-2; black fwd = row+1,
//    start row 1. No en passant, no promotion, no castling, no check detection.
//  - move_cnt increments in the same cycle a mask bit is set; never exceeds N*N-1.
//  - Latency start->done: 2 + SCAN cycles + 1 (FIN). Worst case N=8 queen, centre: 27 marks + 8
//    terminations = 35 SCAN cycles.
// TESTING
//  T1 reset: assert rst=0 mid-SCAN -> busy=0, done=0, moves=0, move_cnt=0 same cycle; no done later.
//  T2 white pawn pos=52 (r6,c4), black piece at 43, rest empty -> moves bits {44,36,43}, move_cnt=3,
//     done 7 cycles after start.
//  T3 white knight pos=0, empty board -> moves bits {10,17}, move_cnt=2, 8 SCAN cycles, err=0.
//  T4 white rook pos=0, empty board -> moves=64'h0101_0101_0101_01FE, move_cnt=14, 18 SCAN cycles.
//  T5 black bishop pos=27 (r3,c3), own piece at 18, white piece at 45 -> 45 marked, 18 unmarked,
//     NE ray {20,13,6}, SW ray {34,41,48}, SE ray {36,45}; move_cnt=8.
//  T6 selected_figure=0 -> err=1, moves=0, done 3 cycles after start; second start during busy ignored.

Source files
------------

// File: rtl/figure_move_gen_seq.sv
// Sequential move generator for one chess figure: snapshots the board on start, examines one
// candidate square per cycle and returns a target mask, move count and error flag.
module figure_move_gen_seq #(
    parameter int N      = 8,
    parameter int CODE_W = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [CODE_W-1:0]      selected_figure_i,
    input  logic [2*$clog2(N)-1:0] position_i,
    input  logic [N*N*CODE_W-1:0]  board_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [N*N-1:0]         moves_o,
    output logic [2*$clog2(N):0]   move_cnt_o,
    output logic                   err_o
);

    localparam int CW    = $clog2(N);
    localparam int CNT_W = 2*CW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N*N - 1);

    localparam logic [2:0] K_P = 3'd0, K_R = 3'd1, K_N = 3'd2,
                           K_B = 3'd3, K_Q = 3'd4, K_K = 3'd5;
    localparam logic [2:0] D_M2 = 3'b110, D_M1 = 3'b111, D_0 = 3'b000,
                           D_P1 = 3'b001, D_P2 = 3'b010;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SCAN, S_FIN} state_t;

    state_t                        state_q;
    logic                          busy_q, done_q, err_q;
    logic [N*N-1:0]                moves_q;
    logic [CNT_W-1:0]              cnt_q;
    logic [N*N-1:0][CODE_W-1:0]    board_q;
    logic [CODE_W-1:0]             fig_q;
    logic [CW-1:0]                 org_r_q, org_c_q, cur_r_q, cur_c_q;
    logic [2:0]                    idx_q, last_q, kind_q;
    logic                          white_q, fwd1_ok_q;

    function automatic logic is_white(input logic [CODE_W-1:0] c);
        return (c >= CODE_W'(1)) && (c <= CODE_W'(6));
    endfunction

    function automatic logic is_black(input logic [CODE_W-1:0] c);
        return (c >= CODE_W'(7)) && (c <= CODE_W'(12));
    endfunction

    logic       fig_white, fig_valid;
    logic [2:0] fig_kind;

    always_comb begin
        fig_white = is_white(fig_q);
        fig_valid = is_white(fig_q) || is_black(fig_q);
        fig_kind  = K_P;
        case (fig_q)
            CODE_W'(2), CODE_W'(8):  fig_kind = K_R;
            CODE_W'(3), CODE_W'(9):  fig_kind = K_N;
            CODE_W'(4), CODE_W'(10): fig_kind = K_B;
            CODE_W'(5), CODE_W'(11): fig_kind = K_Q;
            CODE_W'(6), CODE_W'(12): fig_kind = K_K;
            default:                 fig_kind = K_P;
        endcase
    end

    // Step delta for the current candidate; kings share the slider direction table.
    logic [2:0] dr, dc;

    always_comb begin
        dr = D_0;
        dc = D_0;
        if (kind_q == K_P) begin
            dr = white_q ? D_M1 : D_P1;
            if (idx_q == 3'd1) dr = white_q ? D_M2 : D_P2;
            if (idx_q == 3'd2) dc = D_M1;
            if (idx_q == 3'd3) dc = D_P1;
        end else if (kind_q == K_N) begin
            case (idx_q)
                3'd0:    begin dr = D_M2; dc = D_P1; end
                3'd1:    begin dr = D_M1; dc = D_P2; end
                3'd2:    begin dr = D_P1; dc = D_P2; end
                3'd3:    begin dr = D_P2; dc = D_P1; end
                3'd4:    begin dr = D_P2; dc = D_M1; end
                3'd5:    begin dr = D_P1; dc = D_M2; end
                3'd6:    begin dr = D_M1; dc = D_M2; end
                default: begin dr = D_M2; dc = D_M1; end
            endcase
        end else begin
            case (idx_q)
                3'd0:    begin dr = D_M1; dc = D_0;  end
                3'd1:    begin dr = D_0;  dc = D_P1; end
                3'd2:    begin dr = D_P1; dc = D_0;  end
                3'd3:    begin dr = D_0;  dc = D_M1; end
                3'd4:    begin dr = D_M1; dc = D_P1; end
                3'd5:    begin dr = D_P1; dc = D_P1; end
                3'd6:    begin dr = D_P1; dc = D_M1; end
                default: begin dr = D_M1; dc = D_M1; end
            endcase
        end
    end

    // Two guard bits: a step that leaves 0..N-1 shows up as non-zero upper bits.
    logic [CW+1:0]     tr, tc;
    logic [2*CW-1:0]   tidx;
    logic [CODE_W-1:0] tsq;
    logic              on_board, t_empty, t_enemy, t_own, slider, mark;

    always_comb begin
        tr       = {2'b00, cur_r_q} + {{(CW-1){dr[2]}}, dr};
        tc       = {2'b00, cur_c_q} + {{(CW-1){dc[2]}}, dc};
        on_board = (tr[CW+1:CW] == 2'b00) && (tc[CW+1:CW] == 2'b00);
        tidx     = {tr[CW-1:0], tc[CW-1:0]};
        tsq      = board_q[tidx];
        t_empty  = (tsq == '0);
        t_enemy  = white_q ? is_black(tsq) : is_white(tsq);
        t_own    = !t_empty && !t_enemy;
        slider   = (kind_q == K_R) || (kind_q == K_B) || (kind_q == K_Q);
        mark     = on_board && !t_own;
        if (kind_q == K_P) begin
            case (idx_q)
                3'd0:    mark = on_board && t_empty;
                3'd1:    mark = on_board && t_empty && fwd1_ok_q &&
                                (org_r_q == (white_q ? CW'(N-2) : CW'(1)));
                default: mark = on_board && t_enemy;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            moves_q   <= '0;
            cnt_q     <= '0;
            board_q   <= '0;
            fig_q     <= '0;
            org_r_q   <= '0;
            org_c_q   <= '0;
            cur_r_q   <= '0;
            cur_c_q   <= '0;
            idx_q     <= '0;
            last_q    <= '0;
            kind_q    <= K_P;
            white_q   <= 1'b0;
            fwd1_ok_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i && !busy_q) begin
                        board_q <= board_i;
                        fig_q   <= selected_figure_i;
                        org_r_q <= position_i[2*CW-1:CW];
                        org_c_q <= position_i[CW-1:0];
                        moves_q <= '0;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    cur_r_q   <= org_r_q;
                    cur_c_q   <= org_c_q;
                    kind_q    <= fig_kind;
                    white_q   <= fig_white;
                    fwd1_ok_q <= 1'b0;
                    idx_q     <= (fig_kind == K_B) ? 3'd4 : 3'd0;
                    last_q    <= (fig_kind == K_R || fig_kind == K_P) ? 3'd3 : 3'd7;
                    if (!fig_valid || board_q[{org_r_q, org_c_q}] != fig_q) begin
                        err_q   <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (mark) begin
                        moves_q[tidx] <= 1'b1;
                        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (kind_q == K_P && idx_q == 3'd0) fwd1_ok_q <= on_board && t_empty;
                    if (slider && on_board && t_empty) begin
                        cur_r_q <= tr[CW-1:0];
                        cur_c_q <= tc[CW-1:0];
                    end else begin
                        cur_r_q <= org_r_q;
                        cur_c_q <= org_c_q;
                        if (idx_q == last_q) state_q <= S_FIN;
                        else                 idx_q   <= idx_q + 3'd1;
                    end
                end
                default: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign moves_o    = moves_q;
    assign move_cnt_o = cnt_q;
    assign err_o      = err_q;

endmodule
